data_mem_resp: RTL and testbench

Data-memory responder for the RV32 core: accepts one load or store request at a time from the datapath's memory port and services it after a fixed number of wait cycles. On a store it merges byte/half/word data into a word-organised RAM. On a load it returns the addressed word, right-shifted so that the datapath's funct3 read slicer takes the lane from bit 0. It sits between the core's memory address/data/read-data port and the on-chip data RAM, and flags misaligned, out-of-range or undefined accesses.

---
 rtl/mem_defs.sv | 27 ++
 rtl/store_lane_gen.sv | 40 ++++
 rtl/data_mem_resp.sv | 163 ++++++++++++++++
 tb/tb_data_mem_resp.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the wait-counter width.
package mem_defs;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_half(input logic [2:0] funct3);
        return (funct3 == F3_H) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_BU);
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Decodes funct3 and the low address bits into byte enables, lane-replicated
// store data, and the misalign / illegal-funct3 flags.
module store_lane_gen
    import mem_defs::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic        illegal
);

    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        illegal   = 1'b0;
        if (is_byte(funct3)) begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
        end else if (is_half(funct3)) begin
            byte_en   = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
        end else if (funct3 == F3_W) begin
            byte_en   = 4'b1111;
            misalign  = (addr_lo != 2'b00);
        end else begin
            illegal   = 1'b1;
        end
        // Unsigned variants only exist for loads.
        if (we && (funct3 == F3_BU || funct3 == F3_HU)) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Single-outstanding load/store responder in front of a word-organised data RAM,
// answering after a fixed number of wait cycles.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, counting down wait cycles
// RESP  | one-cycle response strobe on rsp_valid
module data_mem_resp
    import mem_defs::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int                AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]       SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0]  CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cap_we;
    logic [2:0]       cap_funct3;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;

    logic [31:0]      ram [DEPTH_WORDS];

    logic             a_we;
    logic [2:0]       a_funct3;
    logic [31:0]      a_addr;
    logic [31:0]      a_wdata;
    logic [32:0]      offset;
    logic             out_of_range;
    logic [AW-1:0]    word_idx;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic             misalign;
    logic             illegal;
    logic             err;
    logic             do_access;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;

    // With zero latency the access happens on the accepting edge, so it must
    // use the live request rather than the captured copy.
    always_comb begin
        if (state == IDLE) begin
            a_we     = req_we;
            a_funct3 = req_funct3;
            a_addr   = req_addr;
            a_wdata  = req_wdata;
        end else begin
            a_we     = cap_we;
            a_funct3 = cap_funct3;
            a_addr   = cap_addr;
            a_wdata  = cap_wdata;
        end
    end

    store_lane_gen u_lane (
        .we        (a_we),
        .funct3    (a_funct3),
        .addr_lo   (a_addr[1:0]),
        .wdata     (a_wdata),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    // 33-bit subtraction so addresses below BASE_ADDR wrap high and fail.
    assign offset       = {1'b0, a_addr} - {1'b0, BASE_ADDR};
    assign out_of_range = (offset >= SPAN);
    assign word_idx     = offset[AW+1:2];
    assign err          = out_of_range | misalign | illegal;

    assign do_access = ((state == IDLE) && req_valid && (LATENCY == 0))
                     || ((state == WAIT) && (cnt == '0));
    assign wr_en     = do_access && a_we && !err && reset;

    assign rd_word  = ram[word_idx];
    assign rd_shift = rd_word >> {a_addr[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (LATENCY == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= (a_we || err) ? 32'd0 : rd_shift;
                            rsp_err   <= err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (a_we || err) ? 32'd0 : rd_shift;
                        rsp_err   <= err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomised bench for data_mem_resp: byte-level memory model, per-cycle
// response checker, plus handshake spacing checks at LATENCY 0 and 7.
module tb_data_mem_resp;

    localparam int DEPTH = 1024;
    localparam int LAT   = 1;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        sp_valid;
    logic        l0_ready, l0_rvalid, l0_err;
    logic [31:0] l0_rdata;
    logic        l7_ready, l7_rvalid, l7_err;
    logic [31:0] l7_rdata;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        q[$];
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    data_mem_resp #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(32'h0)) u_l0 (
        .clk(clk), .reset(reset), .req_valid(sp_valid), .req_ready(l0_ready),
        .req_we(1'b0), .req_funct3(3'd2), .req_addr(32'h0), .req_wdata(32'h0),
        .rsp_valid(l0_rvalid), .rsp_rdata(l0_rdata), .rsp_err(l0_err)
    );

    data_mem_resp #(.DEPTH_WORDS(16), .LATENCY(7), .BASE_ADDR(32'h0)) u_l7 (
        .clk(clk), .reset(reset), .req_valid(sp_valid), .req_ready(l7_ready),
        .req_we(1'b0), .req_funct3(3'd2), .req_addr(32'h0), .req_wdata(32'h0),
        .rsp_valid(l7_rvalid), .rsp_rdata(l7_rdata), .rsp_err(l7_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Byte-level view of the access rules; updates the model RAM on good stores.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [32:0] off;
        logic [31:0] w;
        int          lo;
        int          idx;
        off = {1'b0, a};
        lo  = int'(a[1:0]);
        er  = (off >= 33'(DEPTH * 4));
        if (f3 == 3'd1 || f3 == 3'd5) er = er | (lo % 2 != 0);
        if (f3 == 3'd2)               er = er | (lo != 0);
        if (we) er = er | (f3 > 3'd2);
        else    er = er | !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        rd = 32'd0;
        if (er) return;
        idx = int'(off[31:2]);
        w   = mdl[idx];
        if (we) begin
            if (f3 == 3'd0)      w[8*lo +: 8]  = wd[7:0];
            else if (f3 == 3'd1) w[8*lo +: 16] = wd[15:0];
            else                 w = wd;
            mdl[idx] = w;
        end else begin
            rd = w >> (8 * lo);
        end
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit expect_rsp,
                         output logic [31:0] rd, output logic er);
        int          n;
        int          acc;
        logic [31:0] m_rd;
        logic        m_er;
        rd = 32'd0;
        er = 1'b0;
        n  = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        if (!req_ready) begin
            fail_now("ready_wait");
            return;
        end
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clk); #2;
        req_valid = 1'b0;
        acc = cyc;
        if (!expect_rsp) return;
        model(we, f3, a, wd, m_rd, m_er);
        q.push_back('{acc + LAT, m_rd, m_er});
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        if (!rsp_valid) begin
            fail_now("rsp_wait");
        end else begin
            rd = rsp_rdata;
            er = rsp_err;
            chk("latency", 32'(cyc - acc), 32'(LAT));
        end
    endtask

    // Per-cycle response checker against the model queue.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (reset === 1'b1) begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    fail_now("rsp_missing");
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("rsp_rdata", rsp_rdata, q[0].rd);
                    chk("rsp_err", 32'(rsp_err), 32'(q[0].er));
                    void'(q.pop_front());
                end else begin
                    chk("rsp_idle", 32'(rsp_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] rd, old20;
        logic        er;
        logic [2:0]  f3;
        logic [31:0] a;
        logic        we;
        bit          h0 [48];
        bit          h7 [48];
        int          p0, p7;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        sp_valid   = 1'b0;
        #12;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #2;

        // Handshake spacing with req_valid held high.
        sp_valid = 1'b1;
        p0 = -1;
        p7 = -1;
        for (int i = 0; i < 48; i++) begin
            h0[i] = l0_ready;
            h7[i] = l7_ready;
            if (l0_ready) begin
                if (p0 >= 0) chk("l0_spacing", 32'(i - p0), 32'd2);
                p0 = i;
            end
            if (l7_ready) begin
                if (p7 >= 0) chk("l7_spacing", 32'(i - p7), 32'd9);
                p7 = i;
            end
            chk("l0_rsp_slot", 32'(l0_rvalid), 32'((i >= 1) && h0[(i >= 1) ? i - 1 : 0]));
            chk("l7_rsp_slot", 32'(l7_rvalid), 32'((i >= 8) && h7[(i >= 8) ? i - 8 : 0]));
            @(negedge clk); #2;
        end
        sp_valid = 1'b0;
        repeat (12) begin
            @(negedge clk); #2;
        end

        for (int w = 0; w < 16; w++) issue(1'b1, 3'd2, 32'(w * 4), $urandom, 1'b1, rd, er);

        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, rd, er);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, rd, er);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);
        chk("lw_deadbeef_err", 32'(er), 32'd0);

        issue(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b1, rd, er);
        issue(1'b1, 3'd0, 32'h13, 32'h000000AA, 1'b1, rd, er);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, rd, er);
        chk("sb_merge", rd, 32'hAA223344);
        issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b1, rd, er);
        chk("lb_lane3", rd, 32'h000000AA);

        issue(1'b1, 3'd1, 32'h12, 32'h0000BEEF, 1'b1, rd, er);
        issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b1, rd, er);
        chk("lh_upper", rd, 32'h0000BEEF);
        issue(1'b1, 3'd1, 32'h11, 32'h00005555, 1'b1, rd, er);
        chk("sh_misalign_err", 32'(er), 32'd1);
        chk("sh_misalign_rdata", rd, 32'd0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, rd, er);
        chk("after_misalign", rd, 32'hBEEF3344);

        issue(1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 1'b1, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        issue(1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0, 1'b1, rd, er);
        chk("oor_high_err", 32'(er), 32'd1);
        issue(1'b1, 3'd3, 32'h10, 32'h01020304, 1'b1, rd, er);
        chk("bad_f3_err", 32'(er), 32'd1);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, rd, er);
        chk("after_bad_f3", rd, 32'hBEEF3344);
        issue(1'b0, 3'd6, 32'h10, 32'h0, 1'b1, rd, er);
        chk("bad_load_f3_err", 32'(er), 32'd1);

        for (int k = 0; k < 150; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else    f3 = (f3 > 3'd5 || f3 == 3'd3) ? 3'd4 : f3;
            end
            if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else                            a = 32'($urandom_range(0, 63));
            issue(we, f3, a, $urandom, 1'b1, rd, er);
        end

        // Reset while a store is waiting: no write, no response.
        old20 = mdl[8];
        issue(1'b1, 3'd2, 32'h20, 32'h12345678, 1'b0, rd, er);
        reset = 1'b0;
        #1;
        chk("wait_reset_ready", 32'(req_ready), 32'd1);
        chk("wait_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wait_reset_rdata", rsp_rdata, 32'd0);
        chk("wait_reset_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #2;
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, rd, er);
        chk("store_discarded", rd, old20);

        repeat (4) begin
            @(negedge clk); #2;
        end
        if (q.size() != 0) fail_now("queue_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
